// File: rtl/layer_bias_streamer.sv
// Bias register file streamed to the conv accumulator, LANES biases per beat, lowest channel in lane 0.
// Optional BIAS_REPEAT_EN: each start runs rep_num_i+1 back-to-back passes.
module layer_bias_streamer #(
  parameter int unsigned BIAS_W = 32,
  parameter int unsigned BUS_W  = 64,
  parameter int unsigned CH_NUM = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              cfg_we_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [BIAS_W-1:0] cfg_wdata_i,
  input  logic              start_i,
  input  logic [7:0]        rep_num_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [BUS_W-1:0]  bias_data_o,
  output logic              bias_valid_o,
  output logic              bias_last_o,
  input  logic              ready_i
);

  localparam int unsigned LANES = BUS_W / BIAS_W;
  localparam int unsigned BEATS = (CH_NUM + LANES - 1) / LANES;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TBL_W = CH_NUM * BIAS_W;
  localparam int unsigned PAD_W = BEATS * BUS_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        rep_left_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic              last_q;
  logic [BUS_W-1:0]  data_q;
  logic [TBL_W-1:0]  tbl_q;

  logic              wr_en_c;
  logic [TBL_W-1:0]  tbl_fwd_c;
  logic [PAD_W-1:0]  tbl_pad_c;
  logic [BUS_W-1:0]  beat_c [BEATS];
  logic [IDX_W-1:0]  nxt_idx_c;
  logic [7:0]        rep_ld_c;

`ifdef BIAS_REPEAT_EN
  assign rep_ld_c = rep_num_i;
`else
  logic unused_rep_c;
  assign rep_ld_c     = 8'd0;
  assign unused_rep_c = ^rep_num_i;
`endif

  // Writes only land while idle so a running pass sees a frozen table.
  assign wr_en_c   = cfg_we_i && (state_q == IDLE);
  assign nxt_idx_c = idx_q + IDX_W'(1);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      tbl_q <= '0;
    end else begin
      for (int c = 0; c < int'(CH_NUM); c++) begin
        if (wr_en_c && (cfg_addr_i == ADDR_W'(c))) begin
          tbl_q[c*BIAS_W +: BIAS_W] <= cfg_wdata_i;
        end
      end
    end
  end

  // Forward a same-cycle write so a start in that cycle streams the new value.
  always_comb begin
    tbl_fwd_c = tbl_q;
    for (int c = 0; c < int'(CH_NUM); c++) begin
      if (wr_en_c && (cfg_addr_i == ADDR_W'(c))) begin
        tbl_fwd_c[c*BIAS_W +: BIAS_W] = cfg_wdata_i;
      end
    end
  end

  assign tbl_pad_c = PAD_W'(tbl_fwd_c);

  for (genvar b = 0; b < int'(BEATS); b++) begin : g_beat
    assign beat_c[b] = tbl_pad_c[b*BUS_W +: BUS_W];
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rep_left_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= SEND;
            idx_q      <= '0;
            rep_left_q <= rep_ld_c;
            busy_q     <= 1'b1;
            valid_q    <= 1'b1;
            data_q     <= beat_c[0];
            last_q     <= (LAST_IDX == '0) && (rep_ld_c == 8'd0);
          end
        end
        SEND: begin
          if (valid_q && ready_i) begin
            if (idx_q == LAST_IDX) begin
              if (rep_left_q != 8'd0) begin
                idx_q      <= '0;
                rep_left_q <= rep_left_q - 8'd1;
                data_q     <= beat_c[0];
                last_q     <= (LAST_IDX == '0) && (rep_left_q == 8'd1);
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                done_q  <= 1'b1;
                data_q  <= '0;
              end
            end else begin
              idx_q  <= nxt_idx_c;
              data_q <= beat_c[nxt_idx_c];
              last_q <= (nxt_idx_c == LAST_IDX) && (rep_left_q == 8'd0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign bias_data_o  = data_q;
  assign bias_valid_o = valid_q;
  assign bias_last_o  = last_q;

endmodule

// File: tb/tb_layer_bias_streamer.sv
// Bench for layer_bias_streamer: 32-channel instance with a beat scoreboard, 5-channel instance table-driven.
module tb_layer_bias_streamer;

  logic sclk = 1'b0;
  logic s_rst_n = 1'b0;
  always #5 sclk = ~sclk;

  // 32-channel, 2-lane instance
  logic        a_we, a_start, a_busy, a_done, a_valid, a_last, a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_wdata;
  logic [7:0]  a_rep;
  logic [63:0] a_data;

  // 5-channel, 2-lane instance
  logic        b_we, b_start, b_busy, b_done, b_valid, b_last, b_ready;
  logic [2:0]  b_addr;
  logic [31:0] b_wdata;
  logic [7:0]  b_rep;
  logic [63:0] b_data;

  layer_bias_streamer #(.BIAS_W(32), .BUS_W(64), .CH_NUM(32), .ADDR_W(5)) u_a (
    .sclk(sclk), .s_rst_n(s_rst_n), .cfg_we_i(a_we), .cfg_addr_i(a_addr), .cfg_wdata_i(a_wdata),
    .start_i(a_start), .rep_num_i(a_rep), .busy_o(a_busy), .done_o(a_done), .bias_data_o(a_data),
    .bias_valid_o(a_valid), .bias_last_o(a_last), .ready_i(a_ready));

  layer_bias_streamer #(.BIAS_W(32), .BUS_W(64), .CH_NUM(5), .ADDR_W(3)) u_b (
    .sclk(sclk), .s_rst_n(s_rst_n), .cfg_we_i(b_we), .cfg_addr_i(b_addr), .cfg_wdata_i(b_wdata),
    .start_i(b_start), .rep_num_i(b_rep), .busy_o(b_busy), .done_o(b_done), .bias_data_o(b_data),
    .bias_valid_o(b_valid), .bias_last_o(b_last), .ready_i(b_ready));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       exp_b;
  logic [31:0] mdl [32];
  logic [63:0] a_log [64];
  int          a_nacc;
  int          a_ndone;
  logic        stall_prev = 1'b0;
  logic [63:0] stall_data;
  logic        stall_last;

  // Scoreboard monitor: pops on every accepted beat, checks holds during stalls.
  always @(negedge sclk) begin
    if (s_rst_n) begin
      if (stall_prev) begin
        check("stall_valid", 64'(a_valid), 64'd1);
        check("stall_data", a_data, stall_data);
        check("stall_last", 64'(a_last), 64'(stall_last));
      end
      if (a_valid && a_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %h expected none", a_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("beat_data", a_data, exp_b.data);
          check("beat_last", 64'(a_last), 64'(exp_b.last));
        end
        if (a_nacc < 64) a_log[a_nacc] = a_data;
        a_nacc++;
      end
      if (a_done) a_ndone++;
      stall_prev = a_valid && !a_ready;
      stall_data = a_data;
      stall_last = a_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ready patterns: 0 always, 1 one-in-three, 2 stall from beat 5, else low
  int rdy_mode = 0;
  int rdy_cnt = 0;
  always @(posedge sclk) begin
    #1;
    case (rdy_mode)
      0:       a_ready = 1'b1;
      1:       a_ready = (rdy_cnt % 3 == 0);
      2:       a_ready = (a_nacc < 5);
      default: a_ready = 1'b0;
    endcase
    rdy_cnt++;
  end

  task automatic a_write(input int idx, input logic [31:0] val);
    a_we = 1'b1; a_addr = 5'(idx); a_wdata = val;
    @(posedge sclk); #1;
    a_we = 1'b0;
  endtask

  task automatic start_a(input logic [7:0] rep);
    int np;
`ifdef BIAS_REPEAT_EN
    np = int'(rep) + 1;
`else
    np = 1;
`endif
    for (int p = 0; p < np; p++)
      for (int b = 0; b < 16; b++)
        exp_q.push_back('{data: {mdl[2*b+1], mdl[2*b]}, last: (p == np - 1) && (b == 15)});
    a_nacc = 0;
    a_ndone = 0;
    a_rep = rep;
    a_start = 1'b1;
    @(posedge sclk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge sclk);
      cyc++;
      if (a_done) break;
      if (cyc >= limit) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] w [5];
    logic [63:0] e [3];
  } bvec_t;
  bvec_t bv [3];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int nb;
    a_we = 0; a_addr = 0; a_wdata = 0; a_start = 0; a_rep = 0; a_ready = 1;
    b_we = 0; b_addr = 0; b_wdata = 0; b_start = 0; b_rep = 0; b_ready = 1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;

    bv[0].w = '{32'd7, 32'(-3), 32'd9, 32'(-199), 32'd4};
    bv[0].e = '{{32'(-3), 32'd7}, {32'(-199), 32'd9}, {32'd0, 32'd4}};
    bv[1].w = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bv[1].e = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    bv[2].w = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    bv[2].e = '{{32'd2, 32'd1}, {32'd4, 32'd3}, {32'd0, 32'd5}};

    repeat (2) @(posedge sclk);
    #1;
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_last", 64'(a_last), 64'd0);
    check("rst_data", a_data, 64'd0);
    s_rst_n = 1'b1;
    @(posedge sclk); #1;

    // Full pass, ready held high
    for (int i = 0; i < 32; i++) begin
      a_write(i, 32'(i + 100));
      mdl[i] = 32'(i + 100);
    end
    rdy_mode = 0;
    start_a(8'd0);
    check("first_valid", 64'(a_valid), 64'd1);
    check("first_busy", 64'(a_busy), 64'd1);
    wait_done(100, cyc);
    check("done_latency", 64'(cyc), 64'd17);
    check("busy_at_done", 64'(a_busy), 64'd0);
    check("valid_at_done", 64'(a_valid), 64'd0);
    @(posedge sclk); #1;
    check("done_pulse", 64'(a_done), 64'd0);
    check("t1_beats", 64'(a_nacc), 64'd16);
    check("t1_beat0", a_log[0], {32'd101, 32'd100});
    check("t1_beat15", a_log[15], {32'd131, 32'd130});
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure one-in-three
    rdy_mode = 1;
    rdy_cnt = 0;
    start_a(8'd0);
    wait_done(200, cyc);
    @(posedge sclk); #1;
    check("t2_beats", 64'(a_nacc), 64'd16);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // start and cfg write while busy are dropped
    rdy_mode = 0;
    start_a(8'd0);
    repeat (3) @(posedge sclk);
    #1;
    a_start = 1'b1; a_we = 1'b1; a_addr = 5'd0; a_wdata = 32'd555;
    @(posedge sclk); #1;
    a_start = 1'b0; a_we = 1'b0;
    wait_done(100, cyc);
    repeat (3) @(posedge sclk);
    #1;
    check("t4_beats", 64'(a_nacc), 64'd16);
    check("t4_ndone", 64'(a_ndone), 64'd1);
    check("t4_idle_busy", 64'(a_busy), 64'd0);
    check("t4_idle_valid", 64'(a_valid), 64'd0);
    start_a(8'd0);
    wait_done(100, cyc);
    @(posedge sclk); #1;
    check("t4_ch0_kept", 64'(a_log[0][31:0]), 64'd100);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // Small table instance: partial final beat
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        b_we = 1'b1; b_addr = 3'(c); b_wdata = bv[r].w[c];
        @(posedge sclk); #1;
      end
      b_we = 1'b0;
      b_start = 1'b1;
      @(posedge sclk); #1;
      b_start = 1'b0;
      nb = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge sclk);
        if (b_valid) begin
          if (nb < 3) begin
            check($sformatf("b%0d_data%0d", r, nb), b_data, bv[r].e[nb]);
            check($sformatf("b%0d_last%0d", r, nb), 64'(b_last), 64'(nb == 2));
          end
          nb++;
        end
        if (b_done) break;
      end
      check($sformatf("b%0d_beats", r), 64'(nb), 64'd3);
      @(posedge sclk); #1;
    end

    // Repeat passes under backpressure
    rdy_mode = 1;
    rdy_cnt = 0;
    start_a(8'd2);
    wait_done(1000, cyc);
    repeat (3) @(posedge sclk);
    #1;
`ifdef BIAS_REPEAT_EN
    check("t6_beats", 64'(a_nacc), 64'd48);
`else
    check("t6_beats", 64'(a_nacc), 64'd16);
`endif
    check("t6_ndone", 64'(a_ndone), 64'd1);
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);

    // Async reset while beat 5 is stalled
    rdy_mode = 2;
    start_a(8'd0);
    for (int k = 0; k < 50 && a_nacc < 5; k++) @(negedge sclk);
    check("t5_reached5", 64'(a_nacc), 64'd5);
    repeat (2) @(posedge sclk);
    #1;
    check("t5_stalled_valid", 64'(a_valid), 64'd1);
    check("t5_stalled_data", a_data, {mdl[11], mdl[10]});
    s_rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(a_valid), 64'd0);
    check("t5_rst_busy", 64'(a_busy), 64'd0);
    check("t5_rst_done", 64'(a_done), 64'd0);
    check("t5_rst_last", 64'(a_last), 64'd0);
    check("t5_rst_data", a_data, 64'd0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    @(posedge sclk); #2;
    s_rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge sclk); #1;
    start_a(8'd0);
    wait_done(100, cyc);
    @(posedge sclk); #1;
    check("t5_beats", 64'(a_nacc), 64'd16);
    check("t5_beat3_zero", a_log[3], 64'd0);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
